fp_divider_seq: RTL and testbench

Iterative IEEE-754-style floating-point divider, out = a / b. It is the inverse-operation companion to the combinational multiplier and shares its operand format, round_mode encoding and exception vector. The block computes one quotient bit per cycle (two with the optional feature) behind valid/ready handshakes, and feeds normalisation and softmax stages of the network datapath.

---
 rtl/fp_divider_seq.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_fp_divider_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_divider_seq.sv
// Iterative floating-point divider (out = a / b), restoring, MSB first.
// Define FP_DIV_RADIX4_EN to retire two quotient bits per DIVIDE cycle.
module fp_divider_seq #(
    parameter int exp_width  = 8,
    parameter int mant_width = 24
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [exp_width+mant_width-1:0] a,
    input  logic [exp_width+mant_width-1:0] b,
    input  logic [2:0]                      round_mode,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [exp_width+mant_width-1:0] out,
    output logic [4:0]                      exceptions
);
    localparam int TW   = exp_width + mant_width;
    localparam int F    = mant_width - 1;
    localparam int QW   = mant_width + 2;
    localparam int RW   = mant_width + 2;
    localparam int EW   = exp_width + 2;
    localparam int BIAS = 2 ** (exp_width - 1) - 1;
    localparam int EMAX = 2 ** exp_width - 1;
`ifdef FP_DIV_RADIX4_EN
    localparam int ITER = (QW + 1) / 2;
    localparam bit ODD  = (QW % 2) == 1;
`else
    localparam int ITER = QW;
`endif
    localparam int CW = $clog2(ITER + 1);

    localparam logic [CW-1:0]        LAST    = CW'(ITER - 1);
    localparam logic signed [EW-1:0] BIAS_S  = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_S  = EW'(EMAX);
    localparam logic signed [EW-1:0] ONE_S   = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S  = '0;
    localparam logic [TW-1:0]        QNAN    =
        {1'b0, {exp_width{1'b1}}, 1'b1, {(F-1){1'b0}}};
    localparam logic [TW-2:0]        INF_MAG = {{exp_width{1'b1}}, {F{1'b0}}};
    localparam logic [TW-2:0]        MAX_MAG =
        {{(exp_width-1){1'b1}}, 1'b0, {F{1'b1}}};

    typedef enum logic [2:0] {IDLE, PREP, DIVIDE, ROUND, DONE} state_t;
    state_t state_q, state_d;

    logic [TW-1:0]           a_q, a_d, b_q, b_d, out_q, out_d;
    logic [2:0]              rm_q, rm_d;
    logic                    sign_q, sign_d, spec_q, spec_d;
    logic signed [EW-1:0]    e_q, e_d;
    logic [RW-1:0]           rem_q, rem_d;
    logic [mant_width-1:0]   div_q, div_d;
    logic [QW-1:0]           quo_q, quo_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4:0]              exc_q, exc_d;

    logic [exp_width-1:0]    ea, eb;
    logic [F-1:0]            fa, fb;
    logic [mant_width-1:0]   ma, mb;
    logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                    any_snan, sgn, lt, special;
    logic signed [EW-1:0]    e_pre;
    logic [TW-1:0]           sp_out;
    logic [4:0]              sp_exc;

    assign ea       = a_q[TW-2 -: exp_width];
    assign eb       = b_q[TW-2 -: exp_width];
    assign fa       = a_q[F-1:0];
    assign fb       = b_q[F-1:0];
    assign ma       = {1'b1, fa};
    assign mb       = {1'b1, fb};
    assign sgn      = a_q[TW-1] ^ b_q[TW-1];
    assign a_zero   = (ea == '0);
    assign b_zero   = (eb == '0);
    assign a_inf    = (&ea) && (fa == '0);
    assign b_inf    = (&eb) && (fb == '0);
    assign a_nan    = (&ea) && (fa != '0);
    assign b_nan    = (&eb) && (fb != '0);
    assign any_snan = (a_nan && !fa[F-1]) || (b_nan && !fb[F-1]);
    assign lt       = ma < mb;
    assign e_pre    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;

    always_comb begin
        special = 1'b1;
        sp_out  = '0;
        sp_exc  = '0;
        if (a_nan || b_nan) begin
            sp_out = QNAN;
            sp_exc = {any_snan, 4'b0000};
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_out = QNAN;
            sp_exc = 5'b10000;
        end else if (a_inf) begin
            sp_out = {sgn, INF_MAG};
        end else if (b_zero) begin
            sp_out = {sgn, INF_MAG};
            sp_exc = 5'b01000;
        end else if (b_inf || a_zero) begin
            sp_out = {sgn, {(TW-1){1'b0}}};
        end else begin
            special = 1'b0;
        end
    end

    // one restoring step: {quotient bit, remainder shifted for next step}
    function automatic logic [RW:0] dstep(input logic [RW-1:0] r,
                                          input logic [mant_width-1:0] d);
        logic          ge;
        logic [RW-1:0] t;
        ge = r >= RW'(d);
        t  = ge ? r - RW'(d) : r;
        return {ge, t[RW-2:0], 1'b0};
    endfunction

    logic [RW:0] s1;
    assign s1 = dstep(rem_q, div_q);
`ifdef FP_DIV_RADIX4_EN
    logic [RW:0] s2;
    assign s2 = dstep(s1[RW-1:0], div_q);
`endif

    logic                 g, rb, st, lsb, inx, up;
    logic [mant_width:0]  mr;
    logic signed [EW-1:0] er;
    logic [F-1:0]         fr;
    logic [TW-1:0]        rnd_out;
    logic [4:0]           rnd_exc;

    always_comb begin
        g   = quo_q[1];
        rb  = quo_q[0];
        lsb = quo_q[2];
        st  = |rem_q;
        inx = g | rb | st;
        case (rm_q)
            3'b001:  up = !sign_q && inx;
            3'b010:  up = sign_q && inx;
            3'b011:  up = 1'b0;
            default: up = g && (rb || st || lsb);
        endcase
        mr = {1'b0, quo_q[QW-1:2]} + (mant_width+1)'(up);
        if (mr[mant_width]) begin
            fr = mr[F:1];
            er = e_q + ONE_S;
        end else begin
            fr = mr[F-1:0];
            er = e_q;
        end
        rnd_exc = {4'b0000, inx};
        rnd_out = {sign_q, er[exp_width-1:0], fr};
        if (er >= EMAX_S) begin
            rnd_exc = 5'b00101;
            case (rm_q)
                3'b001:  rnd_out = {sign_q, sign_q ? MAX_MAG : INF_MAG};
                3'b010:  rnd_out = {sign_q, sign_q ? INF_MAG : MAX_MAG};
                3'b011:  rnd_out = {sign_q, MAX_MAG};
                default: rnd_out = {sign_q, INF_MAG};
            endcase
        end else if (er <= ZERO_S) begin
            rnd_exc = 5'b00011;
            rnd_out = {sign_q, {(TW-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // special results skip DIVIDE but still commit through ROUND
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = PREP;
            PREP:    state_d = special ? ROUND : DIVIDE;
            DIVIDE:  if (cnt_q == LAST) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        out        = out_q;
        exceptions = exc_q;
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        rm_d   = rm_q;
        sign_d = sign_q;
        spec_d = spec_q;
        e_d    = e_q;
        rem_d  = rem_q;
        div_d  = div_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        exc_d  = exc_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d  = a;
                    b_d  = b;
                    rm_d = round_mode;
                end
            end
            PREP: begin
                sign_d = sgn;
                spec_d = special;
                e_d    = lt ? e_pre - ONE_S : e_pre;
                rem_d  = lt ? {1'b0, ma, 1'b0} : {2'b00, ma};
                div_d  = mb;
                quo_d  = '0;
                cnt_d  = '0;
                if (special) begin
                    out_d = sp_out;
                    exc_d = sp_exc;
                end
            end
            DIVIDE: begin
                cnt_d = cnt_q + CW'(1);
`ifdef FP_DIV_RADIX4_EN
                if (ODD && cnt_q == LAST) begin
                    rem_d = s1[RW-1:0];
                    quo_d = {quo_q[QW-2:0], s1[RW]};
                end else begin
                    rem_d = s2[RW-1:0];
                    quo_d = {quo_q[QW-3:0], s1[RW], s2[RW]};
                end
`else
                rem_d = s1[RW-1:0];
                quo_d = {quo_q[QW-2:0], s1[RW]};
`endif
            end
            ROUND: begin
                if (!spec_q) begin
                    out_d = rnd_out;
                    exc_d = rnd_exc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            rm_q   <= '0;
            sign_q <= 1'b0;
            spec_q <= 1'b0;
            e_q    <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
            exc_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            rm_q   <= rm_d;
            sign_q <= sign_d;
            spec_q <= spec_d;
            e_q    <= e_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            exc_q  <= exc_d;
        end
    end

endmodule

// File: tb/tb_fp_divider_seq.sv
// Scoreboard bench for fp_divider_seq: directed cases plus random operands
// checked against an integer-arithmetic reference model.
module tb_fp_divider_seq;
`ifdef FP_DIV_RADIX4_EN
    localparam int NORM_LAT = 15;
`else
    localparam int NORM_LAT = 28;
`endif
    localparam int SPEC_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic [2:0]  round_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [4:0]  exceptions;

    int n_chk  = 0;
    int n_fail = 0;
    logic [36:0] sb[$];

    fp_divider_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .round_mode(round_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .exceptions(exceptions)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference: exact quotient by integer division, then IEEE rounding
    function automatic logic [37:0] model(input logic [31:0] x, y,
                                          input logic [2:0] rm);
        logic s, xz, yz, xi, yi, xn, yn, sn, g, rb, st, up, inx;
        int ex, ey, e;
        longint unsigned mx, my, n, q, r, mant;
        logic [31:0] o;
        logic [4:0] f;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        sn = (xn && !x[22]) || (yn && !y[22]);
        if (xn || yn) return {1'b1, 32'h7FC00000, sn, 4'b0000};
        if ((xz && yz) || (xi && yi)) return {1'b1, 32'h7FC00000, 5'b10000};
        if (xi) return {1'b1, s, 31'h7F800000, 5'b00000};
        if (yz) return {1'b1, s, 31'h7F800000, 5'b01000};
        if (yi || xz) return {1'b1, s, 31'h0, 5'b00000};
        mx = {40'd0, 1'b1, x[22:0]};
        my = {40'd0, 1'b1, y[22:0]};
        n  = mx << 26;
        q  = n / my;
        r  = n % my;
        e  = ex - ey + 127;
        if (q >= (64'd1 << 26)) begin
            mant = q >> 3;
            g  = q[2];
            rb = q[1];
            st = q[0] || (r != 0);
        end else begin
            mant = q >> 2;
            g  = q[1];
            rb = q[0];
            st = (r != 0);
            e  = e - 1;
        end
        inx = g || rb || st;
        case (rm)
            3'd1:    up = !s && inx;
            3'd2:    up = s && inx;
            3'd3:    up = 1'b0;
            default: up = g && (rb || st || mant[0]);
        endcase
        mant = mant + up;
        if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            f = 5'b00101;
            case (rm)
                3'd1:    o = s ? 32'hFF7FFFFF : 32'h7F800000;
                3'd2:    o = s ? 32'hFF800000 : 32'h7F7FFFFF;
                3'd3:    o = {s, 31'h7F7FFFFF};
                default: o = {s, 31'h7F800000};
            endcase
        end else if (e <= 0) begin
            f = 5'b00011;
            o = {s, 31'h0};
        end else begin
            f = {4'b0000, inx};
            o = {s, e[7:0], mant[22:0]};
        end
        return {1'b0, o, f};
    endfunction

    function automatic logic [31:0] rand_op();
        int k;
        logic [31:0] v;
        k = $urandom_range(0, 99);
        v = $urandom;
        if (k < 8) begin
            v[30:23] = 8'h00;
            if (k < 4) v[22:0] = '0;
        end else if (k < 12) begin
            v[30:0] = 31'h7F800000;
        end else if (k < 16) begin
            v[30:23] = 8'hFF;
            v[0] = 1'b1;
        end else if (k < 32) begin
            v[30:23] = ($urandom_range(0, 1) == 1) ?
                8'($urandom_range(1, 12)) : 8'($urandom_range(242, 254));
        end else begin
            v[30:23] = 8'($urandom_range(100, 154));
        end
        return v;
    endfunction

    // call from a posedge+#1 slot; returns with out_valid high (or timeout)
    task automatic issue(input logic [31:0] av, bv, input logic [2:0] rm,
                         input logic [36:0] exp_r, input int exp_lat);
        int w, lat;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            check("in_ready_wait", 64'(in_ready), 64'd1);
            return;
        end
        a = av;
        b = bv;
        round_mode = rm;
        in_valid = 1'b1;
        sb.push_back(exp_r);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {27'd0, out, exceptions}, 64'd0);
            end else begin
                check("result", {27'd0, out, exceptions},
                      {27'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        logic [37:0] m;
        logic [31:0] x, y;
        logic [2:0]  rm;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        round_mode = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out", {27'd0, out, exceptions}, 64'd0);

        issue(32'h40700000, 32'h3FA00000, 3'd0, {32'h40400000, 5'b0}, NORM_LAT);
        issue(32'h3F800000, 32'h40400000, 3'd0, {32'h3EAAAAAB, 5'b00001}, NORM_LAT);
        issue(32'h3F800000, 32'h40400000, 3'd1, {32'h3EAAAAAB, 5'b00001}, NORM_LAT);
        issue(32'h3F800000, 32'h40400000, 3'd2, {32'h3EAAAAAA, 5'b00001}, NORM_LAT);
        issue(32'h3F800000, 32'h40400000, 3'd3, {32'h3EAAAAAA, 5'b00001}, NORM_LAT);
        issue(32'hBFC00000, 32'h00000000, 3'd0, {32'hFF800000, 5'b01000}, SPEC_LAT);
        issue(32'h00000000, 32'h00000000, 3'd0, {32'h7FC00000, 5'b10000}, SPEC_LAT);
        issue(32'h7F800000, 32'h7F800000, 3'd0, {32'h7FC00000, 5'b10000}, SPEC_LAT);
        issue(32'h7F7FFFFF, 32'h3F000000, 3'd0, {32'h7F800000, 5'b00101}, NORM_LAT);
        issue(32'h7F7FFFFF, 32'h3F000000, 3'd3, {32'h7F7FFFFF, 5'b00101}, NORM_LAT);
        issue(32'h00800000, 32'h40000000, 3'd0, {32'h00000000, 5'b00011}, NORM_LAT);

        // backpressure: result must hold and a stray in_valid must be dropped
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(32'h40700000, 32'h3FA00000, 3'd0, {32'h40400000, 5'b0}, NORM_LAT);
        for (int i = 0; i < 5; i++) begin
            check("hold_out", {27'd0, out, exceptions}, {27'd0, 32'h40400000, 5'b0});
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            if (i == 1) begin
                a = 32'h3F800000;
                b = 32'h3F800000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);
        issue(32'h3F800000, 32'h40400000, 3'd0, {32'h3EAAAAAB, 5'b00001}, NORM_LAT);
        @(posedge clk); #1;

        // reset in the middle of DIVIDE
        check("pre_rst_in_ready", 64'(in_ready), 64'd1);
        a = 32'h3F800000;
        b = 32'h40400000;
        round_mode = 3'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out", {27'd0, out, exceptions}, 64'd0);
        issue(32'h40700000, 32'h3FA00000, 3'd0, {32'h40400000, 5'b0}, NORM_LAT);

        for (int i = 0; i < 300; i++) begin
            x  = rand_op();
            y  = rand_op();
            rm = 3'($urandom_range(0, 7));
            m  = model(x, y, rm);
            issue(x, y, rm, m[36:0], m[37] ? SPEC_LAT : NORM_LAT);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
